// File: rtl/pic_host_sequencer.sv
// Bus master that initialises the PIC, serves host EOI/mask writes and runs the
// two-pulse INTA handshake, returning the captured vector to the host.
module pic_host_sequencer #(
  parameter logic [7:0]  ICW1_VAL   = 8'h13,
  parameter logic [7:0]  ICW2_VAL   = 8'h20,
  parameter logic [7:0]  ICW3_VAL   = 8'h00,
  parameter logic [7:0]  ICW4_VAL   = 8'h01,
  parameter logic [7:0]  MASK_INIT  = 8'hFF,
  parameter int unsigned WR_WIDTH   = 2,
  parameter int unsigned INTA_WIDTH = 2,
  parameter int unsigned INTA_GAP   = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  output logic       init_done,
  output logic       busy,
  input  logic       eoi_req,
  output logic       eoi_ack,
  input  logic       mask_wr,
  input  logic [7:0] mask_data,
  output logic       mask_ack,
  input  logic       int_in,
  output logic       vector_valid,
  output logic [7:0] vector,
  input  logic       vector_ack,
  output logic       vector_err,
  output logic       pic_cs_n,
  output logic       pic_rd_n,
  output logic       pic_wr_n,
  output logic       pic_a0,
  output logic [7:0] pic_data,
  output logic       pic_inta_n,
  input  logic [7:0] pic_dout,
  input  logic       pic_data_io
);

  typedef enum logic [3:0] {
    StIdle, StWrSetup, StWrPulse, StWrHold, StWrNext, StInta1, StIntaGap, StInta2, StVecWait
  } state_e;

  typedef enum logic [1:0] {OpInit, OpEoi, OpMask} op_e;

  typedef enum logic [2:0] {StepIcw1, StepIcw2, StepIcw3, StepIcw4, StepOcw1} step_e;

  // ICW3 only exists in cascade mode (SNGL=0), ICW4 only when IC4=1.
  function automatic step_e next_step(input step_e step);
    case (step)
      StepIcw1: next_step = StepIcw2;
      StepIcw2: next_step = !ICW1_VAL[1] ? StepIcw3 : (ICW1_VAL[0] ? StepIcw4 : StepOcw1);
      StepIcw3: next_step = ICW1_VAL[0] ? StepIcw4 : StepOcw1;
      default:  next_step = StepOcw1;
    endcase
  endfunction

  function automatic logic [7:0] step_byte(input step_e step);
    case (step)
      StepIcw1: step_byte = ICW1_VAL;
      StepIcw2: step_byte = ICW2_VAL;
      StepIcw3: step_byte = ICW3_VAL;
      StepIcw4: step_byte = ICW4_VAL;
      default:  step_byte = MASK_INIT;
    endcase
  endfunction

  state_e      r_state;
  op_e         r_op;
  step_e       r_step;
  logic [7:0]  r_cnt;
  logic        r_cs_n, r_wr_n, r_a0, r_inta_n;
  logic [7:0]  r_data;
  logic        r_init_done, r_busy, r_eoi_ack, r_mask_ack;
  logic        r_vector_valid, r_vector_err;
  logic [7:0]  r_vector;
  step_e       w_step_next;

  assign w_step_next = next_step(r_step);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state        <= StIdle;
      r_op           <= OpInit;
      r_step         <= StepIcw1;
      r_cnt          <= '0;
      r_cs_n         <= 1'b1;
      r_wr_n         <= 1'b1;
      r_a0           <= 1'b0;
      r_data         <= '0;
      r_inta_n       <= 1'b1;
      r_init_done    <= 1'b0;
      r_busy         <= 1'b0;
      r_eoi_ack      <= 1'b0;
      r_mask_ack     <= 1'b0;
      r_vector_valid <= 1'b0;
      r_vector       <= '0;
      r_vector_err   <= 1'b0;
    end else begin
      r_eoi_ack  <= 1'b0;
      r_mask_ack <= 1'b0;
      unique case (r_state)
        StIdle: begin
          if (start) begin
            r_init_done    <= 1'b0;
            r_vector_valid <= 1'b0;
            r_op           <= OpInit;
            r_step         <= StepIcw1;
            r_a0           <= 1'b0;
            r_data         <= ICW1_VAL;
            r_cs_n         <= 1'b0;
            r_busy         <= 1'b1;
            r_state        <= StWrSetup;
          end else if (r_init_done && eoi_req) begin
            r_op    <= OpEoi;
            r_a0    <= 1'b0;
            r_data  <= 8'h20;
            r_cs_n  <= 1'b0;
            r_busy  <= 1'b1;
            r_state <= StWrSetup;
          end else if (r_init_done && mask_wr) begin
            r_op    <= OpMask;
            r_a0    <= 1'b1;
            r_data  <= mask_data;
            r_cs_n  <= 1'b0;
            r_busy  <= 1'b1;
            r_state <= StWrSetup;
          end else if (r_init_done && int_in) begin
            r_inta_n <= 1'b0;
            r_cnt    <= 8'(INTA_WIDTH - 1);
            r_busy   <= 1'b1;
            r_state  <= StInta1;
          end
        end
        StWrSetup: begin
          r_wr_n  <= 1'b0;
          r_cnt   <= 8'(WR_WIDTH - 1);
          r_state <= StWrPulse;
        end
        StWrPulse: begin
          if (r_cnt == '0) begin
            r_wr_n  <= 1'b1;
            r_state <= StWrHold;
          end else begin
            r_cnt <= r_cnt - 8'd1;
          end
        end
        StWrHold: begin
          r_cs_n     <= 1'b1;
          r_eoi_ack  <= (r_op == OpEoi);
          r_mask_ack <= (r_op == OpMask);
          if (r_op == OpInit && r_step == StepOcw1) r_init_done <= 1'b1;
          r_state    <= StWrNext;
        end
        StWrNext: begin
          // Init writes chain back-to-back; everything else returns to arbitration.
          if (r_op == OpInit && r_step != StepOcw1) begin
            r_step  <= w_step_next;
            r_a0    <= 1'b1;
            r_data  <= step_byte(w_step_next);
            r_cs_n  <= 1'b0;
            r_state <= StWrSetup;
          end else begin
            r_busy  <= 1'b0;
            r_state <= StIdle;
          end
        end
        StInta1: begin
          if (r_cnt == '0) begin
            r_inta_n <= 1'b1;
            r_cnt    <= 8'(INTA_GAP - 1);
            r_state  <= StIntaGap;
          end else begin
            r_cnt <= r_cnt - 8'd1;
          end
        end
        StIntaGap: begin
          if (r_cnt == '0) begin
            r_inta_n <= 1'b0;
            r_cnt    <= 8'(INTA_WIDTH - 1);
            r_state  <= StInta2;
          end else begin
            r_cnt <= r_cnt - 8'd1;
          end
        end
        StInta2: begin
          if (r_cnt == '0) begin
            r_inta_n       <= 1'b1;
            r_vector       <= pic_dout;
            r_vector_err   <= pic_data_io;
            r_vector_valid <= 1'b1;
            r_state        <= StVecWait;
          end else begin
            r_cnt <= r_cnt - 8'd1;
          end
        end
        StVecWait: begin
          if (vector_ack) begin
            r_vector_valid <= 1'b0;
            r_busy         <= 1'b0;
            r_state        <= StIdle;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign init_done    = r_init_done;
  assign busy         = r_busy;
  assign eoi_ack      = r_eoi_ack;
  assign mask_ack     = r_mask_ack;
  assign vector_valid = r_vector_valid;
  assign vector       = r_vector;
  assign vector_err   = r_vector_err;
  assign pic_cs_n     = r_cs_n;
  assign pic_rd_n     = 1'b1;
  assign pic_wr_n     = r_wr_n;
  assign pic_a0       = r_a0;
  assign pic_data     = r_data;
  assign pic_inta_n   = r_inta_n;

endmodule

// File: tb/tb_pic_host_sequencer.sv
// Bench for pic_host_sequencer: directed timeline plus random host/PIC traffic,
// checked every cycle against a waveform-queue model of the bus protocol.
module tb_pic_host_sequencer;

  localparam logic [7:0]  TB_ICW1 = 8'h13;
  localparam logic [7:0]  TB_ICW2 = 8'h20;
  localparam logic [7:0]  TB_ICW3 = 8'h00;
  localparam logic [7:0]  TB_ICW4 = 8'h01;
  localparam logic [7:0]  TB_MASK = 8'hFF;
  localparam int unsigned TB_WRW  = 2;
  localparam int unsigned TB_INW  = 2;
  localparam int unsigned TB_GAP  = 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset, start, eoi_req, mask_wr, int_in, vector_ack, pic_data_io;
  logic [7:0] mask_data, pic_dout;
  logic       init_done, busy, eoi_ack, mask_ack, vector_valid, vector_err;
  logic [7:0] vector, pic_data;
  logic       pic_cs_n, pic_rd_n, pic_wr_n, pic_a0, pic_inta_n;

  pic_host_sequencer #(
    .ICW1_VAL(TB_ICW1), .ICW2_VAL(TB_ICW2), .ICW3_VAL(TB_ICW3), .ICW4_VAL(TB_ICW4),
    .MASK_INIT(TB_MASK), .WR_WIDTH(TB_WRW), .INTA_WIDTH(TB_INW), .INTA_GAP(TB_GAP)
  ) u_dut (
    .clk(clk), .reset(reset), .start(start), .init_done(init_done), .busy(busy),
    .eoi_req(eoi_req), .eoi_ack(eoi_ack), .mask_wr(mask_wr), .mask_data(mask_data),
    .mask_ack(mask_ack), .int_in(int_in), .vector_valid(vector_valid), .vector(vector),
    .vector_ack(vector_ack), .vector_err(vector_err), .pic_cs_n(pic_cs_n),
    .pic_rd_n(pic_rd_n), .pic_wr_n(pic_wr_n), .pic_a0(pic_a0), .pic_data(pic_data),
    .pic_inta_n(pic_inta_n), .pic_dout(pic_dout), .pic_data_io(pic_data_io)
  );

  // Two extra instances exercising the optional ICW3/ICW4 steps.
  logic       reset_b, start_b;
  logic       b_done, b_busy, b_eack, b_mack, b_vv, b_ve, b_cs, b_rd, b_wr, b_a0, b_inta;
  logic [7:0] b_vec, b_data;
  logic       c_done, c_busy, c_eack, c_mack, c_vv, c_ve, c_cs, c_rd, c_wr, c_a0, c_inta;
  logic [7:0] c_vec, c_data;

  pic_host_sequencer #(.ICW1_VAL(8'h11)) u_dut_b (
    .clk(clk), .reset(reset_b), .start(start_b), .init_done(b_done), .busy(b_busy),
    .eoi_req(1'b0), .eoi_ack(b_eack), .mask_wr(1'b0), .mask_data(8'h00),
    .mask_ack(b_mack), .int_in(1'b0), .vector_valid(b_vv), .vector(b_vec),
    .vector_ack(1'b0), .vector_err(b_ve), .pic_cs_n(b_cs), .pic_rd_n(b_rd),
    .pic_wr_n(b_wr), .pic_a0(b_a0), .pic_data(b_data), .pic_inta_n(b_inta),
    .pic_dout(8'h00), .pic_data_io(1'b1)
  );

  pic_host_sequencer #(.ICW1_VAL(8'h12)) u_dut_c (
    .clk(clk), .reset(reset_b), .start(start_b), .init_done(c_done), .busy(c_busy),
    .eoi_req(1'b0), .eoi_ack(c_eack), .mask_wr(1'b0), .mask_data(8'h00),
    .mask_ack(c_mack), .int_in(1'b0), .vector_valid(c_vv), .vector(c_vec),
    .vector_ack(1'b0), .vector_err(c_ve), .pic_cs_n(c_cs), .pic_rd_n(c_rd),
    .pic_wr_n(c_wr), .pic_a0(c_a0), .pic_data(c_data), .pic_inta_n(c_inta),
    .pic_dout(8'h00), .pic_data_io(1'b1)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at t=%0t: got %h, expected %h", name, $time, act, exp);
    end
  endtask

  // ---------------- reference model: queue of expected per-cycle pin states ----------------
  typedef struct packed {
    logic       cs_n, wr_n, inta_n, a0;
    logic [7:0] data;
    logic       busy, eoi_ack, mask_ack, done_set, capture, rst;
  } cyc_t;

  cyc_t       q[$];
  cyc_t       cur;
  logic       m_ok = 1'b0;
  logic       m_done, m_valid, m_err, m_wait;
  logic [7:0] m_vec;

  function automatic cyc_t idle_c();
    cyc_t c;
    c = '0;
    c.cs_n = 1'b1; c.wr_n = 1'b1; c.inta_n = 1'b1;
    return c;
  endfunction

  // kind: 0 init, 1 eoi, 2 mask. An idle cycle follows any write that ends a transaction.
  task automatic push_write(input logic [7:0] d, input logic a0, input int kind, input bit last);
    cyc_t c;
    c = idle_c();
    c.busy = 1'b1; c.a0 = a0; c.data = d; c.cs_n = 1'b0;
    q.push_back(c);
    c.wr_n = 1'b0;
    for (int i = 0; i < int'(TB_WRW); i++) q.push_back(c);
    c.wr_n = 1'b1;
    q.push_back(c);
    c.cs_n = 1'b1; c.eoi_ack = (kind == 1); c.mask_ack = (kind == 2); c.done_set = last;
    q.push_back(c);
    if (kind != 0 || last) q.push_back(idle_c());
  endtask

  task automatic push_inta();
    cyc_t c;
    c = idle_c();
    c.busy = 1'b1;
    c.inta_n = 1'b0;
    for (int i = 0; i < int'(TB_INW); i++) q.push_back(c);
    c.inta_n = 1'b1;
    for (int i = 0; i < int'(TB_GAP); i++) q.push_back(c);
    c.inta_n = 1'b0;
    for (int i = 0; i < int'(TB_INW); i++) q.push_back(c);
    c.inta_n = 1'b1; c.capture = 1'b1;
    q.push_back(c);
  endtask

  always @(posedge clk) begin
    if (reset) begin
      q.delete();
      cur = idle_c(); cur.rst = 1'b1;
      m_done = 1'b0; m_valid = 1'b0; m_err = 1'b0; m_wait = 1'b0; m_vec = 8'h00;
      m_ok = 1'b1;
    end else if (m_ok) begin
      if (q.size() > 0) begin
        cur = q.pop_front();
      end else if (m_wait) begin
        if (vector_ack) begin
          m_wait = 1'b0; m_valid = 1'b0; cur = idle_c();
        end
      end else begin
        cur = idle_c();
        if (start) begin
          m_done = 1'b0; m_valid = 1'b0;
          push_write(TB_ICW1, 1'b0, 0, 0);
          push_write(TB_ICW2, 1'b1, 0, 0);
          if (!TB_ICW1[1]) push_write(TB_ICW3, 1'b1, 0, 0);
          if (TB_ICW1[0]) push_write(TB_ICW4, 1'b1, 0, 0);
          push_write(TB_MASK, 1'b1, 0, 1);
        end else if (m_done && eoi_req) push_write(8'h20, 1'b0, 1, 0);
        else if (m_done && mask_wr) push_write(mask_data, 1'b1, 2, 0);
        else if (m_done && int_in) push_inta();
        if (q.size() > 0) cur = q.pop_front();
      end
      if (cur.done_set) m_done = 1'b1;
      if (cur.capture) begin
        m_vec = pic_dout; m_err = pic_data_io; m_valid = 1'b1; m_wait = 1'b1;
        cur.capture = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (m_ok) begin
      chk("cs_n", pic_cs_n, cur.cs_n);
      chk("wr_n", pic_wr_n, cur.wr_n);
      chk("rd_n", pic_rd_n, 1'b1);
      chk("inta_n", pic_inta_n, cur.inta_n);
      chk("busy", busy, cur.busy);
      chk("eoi_ack", eoi_ack, cur.eoi_ack);
      chk("mask_ack", mask_ack, cur.mask_ack);
      chk("init_done", init_done, m_done);
      chk("vector_valid", vector_valid, m_valid);
      chk("vector", vector, m_vec);
      chk("vector_err", vector_err, m_err);
      chk("cs_inta_excl", pic_cs_n | pic_inta_n, 1'b1);
      if (!cur.cs_n || cur.rst) begin
        chk("a0", pic_a0, cur.a0);
        chk("data", pic_data, cur.data);
      end
    end
  end

  // Bytes written (a0 in bit 8) at each falling WR_n, per instance.
  logic [8:0] log_a[$], log_b[$], log_c[$];
  logic       pa = 1'b1, pb = 1'b1, pc = 1'b1;
  int         wrlow_a = 0;
  always @(negedge clk) begin
    if (pic_wr_n === 1'b0 && pa === 1'b1) log_a.push_back({pic_a0, pic_data});
    if (b_wr === 1'b0 && pb === 1'b1) log_b.push_back({b_a0, b_data});
    if (c_wr === 1'b0 && pc === 1'b1) log_c.push_back({c_a0, c_data});
    if (pic_wr_n === 1'b0) wrlow_a++;
    pa = pic_wr_n; pb = b_wr; pc = c_wr;
  end

  logic [8:0] exp_a [4] = '{9'h013, 9'h120, 9'h101, 9'h1FF};
  logic [8:0] exp_b [5] = '{9'h011, 9'h120, 9'h100, 9'h101, 9'h1FF};
  logic [8:0] exp_c [3] = '{9'h012, 9'h120, 9'h1FF};

  task automatic chk_log(input string name, input logic [8:0] got[$], input logic [8:0] exp[],
                         input int n);
    chk(name, 16'(got.size()), 16'(n));
    for (int i = 0; i < n && i < got.size(); i++) chk(name, got[i], exp[i]);
  endtask

  // Literal inta_n pattern for cycles 22..27 of the first interrupt.
  logic inta_pat [6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};

  initial begin
    reset = 1'b1; reset_b = 1'b1; start = 1'b0; start_b = 1'b0;
    eoi_req = 1'b0; mask_wr = 1'b0; mask_data = 8'h00; int_in = 1'b0;
    vector_ack = 1'b0; pic_dout = 8'h00; pic_data_io = 1'b1;
    repeat (3) @(negedge clk);
    // cycle 0
    reset = 1'b0; reset_b = 1'b0; start = 1'b1; start_b = 1'b1;
    log_a.delete(); log_b.delete(); log_c.delete(); wrlow_a = 0;
    for (int c = 1; c <= 100; c++) begin
      @(negedge clk);
      if (c >= 22 && c <= 27) chk("inta_seq", pic_inta_n, inta_pat[c-22]);
      case (c)
        1:  begin start = 1'b0; start_b = 1'b0; chk("busy_c1", busy, 1'b1); end
        14: chk("c_done_c14", c_done, 1'b0);
        15: begin chk("c_done_c15", c_done, 1'b1); chk_log("c_writes", log_c, exp_c, 3); end
        19: chk("done_c19", init_done, 1'b0);
        20: begin chk("done_c20", init_done, 1'b1); chk("busy_c20", busy, 1'b1); end
        21: begin
          chk("busy_c21", busy, 1'b0);
          chk_log("a_writes", log_a, exp_a, 4);
          chk("wr_low_cycles", 16'(wrlow_a), 16'd8);
          int_in = 1'b1; pic_dout = 8'h23; pic_data_io = 1'b0;
        end
        22: int_in = 1'b0;
        24: chk("b_done_c24", b_done, 1'b0);
        25: begin chk("b_done_c25", b_done, 1'b1); chk_log("b_writes", log_b, exp_b, 5); end
        27: begin
          chk("vv_c27", vector_valid, 1'b1); chk("vec_c27", vector, 8'h23);
          chk("err_c27", vector_err, 1'b0);
        end
        30: begin chk("vv_c30", vector_valid, 1'b1); vector_ack = 1'b1; end
        31: begin
          vector_ack = 1'b0; chk("vv_c31", vector_valid, 1'b0); chk("busy_c31", busy, 1'b0);
          eoi_req = 1'b1; mask_wr = 1'b1; mask_data = 8'hF0; int_in = 1'b1;
        end
        32: chk("eoi_wr", {pic_cs_n, pic_a0, pic_data}, {2'b00, 8'h20});
        36: begin chk("eoi_ack_c36", eoi_ack, 1'b1); eoi_req = 1'b0; end
        37: chk("eoi_ack_c37", eoi_ack, 1'b0);
        38: chk("mask_wr", {pic_cs_n, pic_a0, pic_data}, {2'b01, 8'hF0});
        42: begin chk("mask_ack_c42", mask_ack, 1'b1); mask_wr = 1'b0; end
        43: chk("mask_ack_c43", mask_ack, 1'b0);
        44: begin
          chk("inta_c44", pic_inta_n, 1'b0);
          int_in = 1'b0; pic_data_io = 1'b1; pic_dout = 8'h5A;
        end
        49: begin
          chk("err_c49", vector_err, 1'b1); chk("vec_c49", vector, 8'h5A);
          chk("vv_c49", vector_valid, 1'b1); eoi_req = 1'b1;
        end
        52: begin chk("eoi_held_off", pic_cs_n, 1'b1); vector_ack = 1'b1; end
        53: begin vector_ack = 1'b0; chk("vv_c53", vector_valid, 1'b0); end
        54: chk("eoi_after_ack", {pic_cs_n, pic_data}, {1'b0, 8'h20});
        58: begin chk("eoi_ack_c58", eoi_ack, 1'b1); eoi_req = 1'b0; end
        60: start = 1'b1;
        61: start = 1'b0;
        62: begin chk("wr_pulse_c62", pic_wr_n, 1'b0); reset = 1'b1; end
        63: begin
          chk("rst_wr", {pic_wr_n, pic_cs_n, pic_inta_n, init_done, busy}, 5'b11100);
          reset = 1'b0; int_in = 1'b1;
        end
        70: chk("int_ignored", {pic_inta_n, busy}, 2'b10);
        73: start = 1'b1;
        74: start = 1'b0;
        93: chk("done_c93", init_done, 1'b1);
        98: begin chk("inta2_c98", pic_inta_n, 1'b0); reset = 1'b1; end
        99: begin
          chk("rst_inta", {pic_wr_n, pic_cs_n, pic_inta_n, init_done, busy, vector_valid},
              6'b111000);
          reset = 1'b0; int_in = 1'b0;
        end
        default: ;
      endcase
    end

    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      reset = ($urandom_range(0, 299) == 0);
      start = ($urandom_range(0, 59) == 0);
      if (!eoi_req) eoi_req = ($urandom_range(0, 14) == 0);
      else if (eoi_ack) eoi_req = 1'b0;
      if (!mask_wr) begin
        mask_wr = ($urandom_range(0, 14) == 0);
        mask_data = 8'($urandom);
      end else if (mask_ack) mask_wr = 1'b0;
      if ($urandom_range(0, 5) == 0) int_in = ~int_in;
      vector_ack = ($urandom_range(0, 3) == 0);
      pic_dout = 8'($urandom);
      pic_data_io = 1'($urandom);
    end
    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
